rgb_to_raw_mode_ctrl: RTL and testbench
=======================================

Name: rgb_to_raw_mode_ctrl

Overview:
Configuration sequencer for the rgb_to_raw converter. It accepts mode requests (TRANSFER_MODE, RAW_BIT_NUM) through a valid/ready handshake and checks them for legality. Legal requests are held pending and committed to the converter only at a frame boundary (rising edge of S_VS), so a mode never changes mid-frame. It also monitors the input video timing and reports frame and line counts to software.

Parameters:
C_INIT_MODE, 0, TRANSFER_MODE value after reset (0 ORIGINAL, 1 YUV_TO_YUV422, 2 RGB_TO_RGGB).
C_INIT_BITS, 2, RAW_BIT_NUM value after reset (0 = 8 bit, 1 = 10 bit, 2 = 12 bit).
C_SETTLE_CYCLES, 4, cycles BUSY stays high after a commit, covering converter pipeline flush; legal range 1..255.
C_FRAME_CNT_W, 16, width of FRAME_CNT.
C_LINE_CNT_W, 12, width of LINE_CNT.

Ports:
VID_CLK  in  1  video clock; only clock in the block.
VID_RST  in  1  synchronous, active-high reset.
S_VS  in  1  input vertical sync, active high (same signal that feeds the converter).
S_HS  in  1  input horizontal sync, active high; monitored only.
S_DE  in  1  input data enable.
CFG_VALID  in  1  request valid.
CFG_READY  out  1  request ready.
CFG_TRANSFER_MODE  in  2  requested transfer mode.
CFG_RAW_BIT_NUM  in  2  requested raw bit depth.
CFG_ERR  out  1  one-cycle pulse: the accepted request was illegal.
TRANSFER_MODE  out  2  committed mode, drives the converter.
RAW_BIT_NUM  out  2  committed bit depth, drives the converter.
MODE_UPDATE  out  1  one-cycle pulse: a new configuration was committed.
BUSY  out  1  high while a request is pending or settling.
FRAME_CNT  out  C_FRAME_CNT_W  count of S_VS rising edges, wraps.
LINE_CNT  out  C_LINE_CNT_W  count of active lines (S_DE falling edges) in the current frame.

Behaviour:
- Clocking and reset: all state is on VID_CLK. When VID_RST=1 at an edge, the block returns to reset state.
- Reset values:
  - TRANSFER_MODE=C_INIT_MODE, RAW_BIT_NUM=C_INIT_BITS.
  - CFG_ERR=0, MODE_UPDATE=0, BUSY=0, FRAME_CNT=0, LINE_CNT=0.
  - State IDLE; pending request discarded; edge-detect registers cleared.
- Edge detection: S_VS and S_DE are registered.
  - vs_rise = S_VS & ~vs_d.
  - de_fall = ~S_DE & de_d.
  - Because vs_d resets to 0, an S_VS held high through reset counts as one rise on the first cycle after reset.
- Handshake: a transfer happens on a cycle where CFG_VALID & CFG_READY.
  - CFG_READY = (state==IDLE) | (state==PENDING & ~vs_rise). It is combinational and 0 during reset.
- Legality: a request is illegal if CFG_TRANSFER_MODE==3 or CFG_RAW_BIT_NUM==3.
  - An illegal request is still accepted.
  - CFG_ERR pulses for one cycle, the cycle after the transfer.
  - State, pending value and outputs are unchanged.
- FSM:
  - IDLE: legal transfer -> store pending value, go to PENDING.
  - PENDING: legal transfer -> overwrite pending value (latest wins), stay in PENDING.
  - PENDING, vs_rise -> load TRANSFER_MODE/RAW_BIT_NUM from pending, MODE_UPDATE=1 next cycle, settle counter = C_SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: count down each cycle; at 0 go to IDLE. CFG_READY=0.
- BUSY = (state != IDLE), registered with the state.
- Simultaneous events:
  - In IDLE, a transfer in the same cycle as vs_rise is stored, but it waits for the next vs_rise.
  - In PENDING, vs_rise blocks READY, so the commit always uses the value held before that cycle.
- Timing: the outputs change at the edge that samples vs_rise; MODE_UPDATE is high during the cycle that follows. Commit latency is one edge from S_VS rising.
- Counters:
  - FRAME_CNT += 1 on vs_rise, modulo 2^C_FRAME_CNT_W.
  - LINE_CNT clears on vs_rise and increments on de_fall.
  - If both occur in the same cycle, the clear wins (LINE_CNT=0).
  - LINE_CNT saturates at all-ones.
- S_HS is only observed; no output depends on it. It is reserved for later line-based status.
- Reset during PENDING or SETTLE: the pending request is lost; outputs return to the init values.

Decomposition:
- Shared package rgb_to_raw_pkg:
  - transfer-mode constants MODE_ORIGINAL=0, MODE_YUV422=1, MODE_RGGB=2.
  - bit constants BITS_8=0, BITS_10=1, BITS_12=2.
  - FSM state enum {IDLE, PENDING, SETTLE}.
  - Legality-check function.
- One natural sub-module: vid_timing_mon. It contains the edge detectors, FRAME_CNT and LINE_CNT, and exports vs_rise. The FSM stays in the top module.

Test Plan:
1. Release reset -> TRANSFER_MODE=0, RAW_BIT_NUM=2, BUSY=0, CFG_READY=1, FRAME_CNT=0.
2. Request mode=1, bits=1 mid-frame -> BUSY=1, outputs unchanged until the next S_VS rise; then TRANSFER_MODE=1, RAW_BIT_NUM=1, MODE_UPDATE high 1 cycle, BUSY low exactly 4 cycles later.
3. Request mode=3, bits=0 -> accepted; CFG_ERR one pulse the next cycle; outputs and BUSY unchanged.
4. In PENDING, request (1,0) then (2,2), then pulse S_VS -> committed (2,2). A request presented on the S_VS-rise cycle sees CFG_READY=0.
5. Frame with S_VS pulse, 4 S_HS pulses, 2 DE bursts of 100 cycles -> FRAME_CNT +1, LINE_CNT=2; the next S_VS clears LINE_CNT to 0.
6. Assert VID_RST for 1 cycle while in PENDING with (2,0) -> outputs return to (0,2); a later S_VS commits nothing and MODE_UPDATE stays 0.

Source files
------------

// File: rtl/rgb_to_raw_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rgb_to_raw_pkg
//  Description : Shared definitions for the rgb_to_raw mode controller:
//                transfer-mode and bit-depth codes, the sequencer state
//                encoding and the request legality check.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_to_raw_pkg;

    // TRANSFER_MODE codes understood by the converter
    localparam logic [1:0] MODE_ORIGINAL = 2'd0;
    localparam logic [1:0] MODE_YUV422   = 2'd1;
    localparam logic [1:0] MODE_RGGB    = 2'd2;

    // RAW_BIT_NUM codes understood by the converter
    localparam logic [1:0] BITS_8  = 2'd0;
    localparam logic [1:0] BITS_10 = 2'd1;
    localparam logic [1:0] BITS_12 = 2'd2;

    // Sequencer states, explicitly encoded
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SETTLE  = 2'd2
    } cfg_state_t;

    // Code 3 is unassigned for both fields; any request using it is rejected.
    function automatic logic cfg_is_legal(input logic [1:0] mode,
                                          input logic [1:0] bits);
        return (mode != 2'd3) && (bits != 2'd3);
    endfunction

endpackage : rgb_to_raw_pkg
`default_nettype wire

// File: rtl/vid_timing_mon.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : vid_timing_mon
//  Description : Input video timing monitor. Detects S_VS rising and S_DE
//                falling edges, counts frames (wrapping) and active lines in
//                the current frame (saturating).
//  Ports       : clk, rst         - clock / synchronous active-high reset
//                i_s_vs, i_s_de   - video sync inputs
//                o_vs_rise        - combinational frame-start strobe
//                o_frame_cnt      - S_VS rising edges seen, wraps
//                o_line_cnt       - S_DE falling edges since last frame start
//  Revision    : 1.0 - initial release
// ============================================================================
module vid_timing_mon #(
    parameter int C_FRAME_CNT_W = 16,
    parameter int C_LINE_CNT_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_s_vs,
    input  logic                     i_s_de,
    output logic                     o_vs_rise,
    output logic [C_FRAME_CNT_W-1:0] o_frame_cnt,
    output logic [C_LINE_CNT_W-1:0]  o_line_cnt
);

    logic                     r_vs_d;
    logic                     r_de_d;
    logic                     w_de_fall;
    logic [C_FRAME_CNT_W-1:0] r_frame_cnt;
    logic [C_LINE_CNT_W-1:0]  r_line_cnt;

    // r_vs_d clears in reset, so a sync held high through reset is seen as
    // a frame start on the first cycle out of reset.
    assign o_vs_rise = i_s_vs & ~r_vs_d;
    assign w_de_fall = ~i_s_de & r_de_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vs_d      <= 1'b0;
            r_de_d      <= 1'b0;
            r_frame_cnt <= '0;
            r_line_cnt  <= '0;
        end else begin
            r_vs_d <= i_s_vs;
            r_de_d <= i_s_de;
            if (o_vs_rise) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            // A frame start wins over a coincident line end
            if (o_vs_rise) begin
                r_line_cnt <= '0;
            end else if (w_de_fall && (r_line_cnt != '1)) begin
                r_line_cnt <= r_line_cnt + 1'b1;
            end
        end
    end

    assign o_frame_cnt = r_frame_cnt;
    assign o_line_cnt  = r_line_cnt;

endmodule : vid_timing_mon
`default_nettype wire

// File: rtl/rgb_to_raw_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : rgb_to_raw_mode_ctrl
//  Description : Configuration sequencer for the rgb_to_raw converter.
//                Accepts (TRANSFER_MODE, RAW_BIT_NUM) requests over a
//                valid/ready handshake, flags illegal ones, and commits the
//                latest legal request only at a frame start so the mode
//                never changes mid-frame. Also reports frame/line counts.
//  Ports       : VID_CLK, VID_RST          - clock / sync active-high reset
//                S_VS, S_HS, S_DE          - monitored video timing
//                CFG_VALID/READY/...       - request handshake and payload
//                CFG_ERR                   - pulse: accepted request illegal
//                TRANSFER_MODE, RAW_BIT_NUM- committed converter settings
//                MODE_UPDATE               - pulse: new settings committed
//                BUSY                      - request pending or settling
//                FRAME_CNT, LINE_CNT       - timing status
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_to_raw_mode_ctrl
    import rgb_to_raw_pkg::*;
#(
    parameter int C_INIT_MODE     = 0,
    parameter int C_INIT_BITS     = 2,
    parameter int C_SETTLE_CYCLES = 4,
    parameter int C_FRAME_CNT_W   = 16,
    parameter int C_LINE_CNT_W    = 12
) (
    input  logic                     VID_CLK,
    input  logic                     VID_RST,
    input  logic                     S_VS,
    input  logic                     S_HS,
    input  logic                     S_DE,
    input  logic                     CFG_VALID,
    output logic                     CFG_READY,
    input  logic [1:0]               CFG_TRANSFER_MODE,
    input  logic [1:0]               CFG_RAW_BIT_NUM,
    output logic                     CFG_ERR,
    output logic [1:0]               TRANSFER_MODE,
    output logic [1:0]               RAW_BIT_NUM,
    output logic                     MODE_UPDATE,
    output logic                     BUSY,
    output logic [C_FRAME_CNT_W-1:0] FRAME_CNT,
    output logic [C_LINE_CNT_W-1:0]  LINE_CNT
);

    localparam logic [1:0] C_INIT_MODE_V   = 2'(C_INIT_MODE);
    localparam logic [1:0] C_INIT_BITS_V   = 2'(C_INIT_BITS);
    localparam logic [7:0] C_SETTLE_LOAD   = 8'(C_SETTLE_CYCLES - 1);

    cfg_state_t r_state;
    cfg_state_t w_state_nxt;

    logic       w_vs_rise;
    logic       w_xfer;
    logic       w_legal;
    logic       w_store;
    logic       w_commit;
    logic       w_unused_hs;

    logic [1:0] r_pend_mode;
    logic [1:0] r_pend_bits;
    logic [1:0] r_mode;
    logic [1:0] r_bits;
    logic       r_mode_update;
    logic       r_cfg_err;
    logic [7:0] r_settle_cnt;

    // Horizontal sync is observed only; nothing depends on it yet.
    assign w_unused_hs = S_HS;

    vid_timing_mon #(
        .C_FRAME_CNT_W (C_FRAME_CNT_W),
        .C_LINE_CNT_W  (C_LINE_CNT_W)
    ) u_timing_mon (
        .clk         (VID_CLK),
        .rst         (VID_RST),
        .i_s_vs      (S_VS),
        .i_s_de      (S_DE),
        .o_vs_rise   (w_vs_rise),
        .o_frame_cnt (FRAME_CNT),
        .o_line_cnt  (LINE_CNT)
    );

    // While pending, the frame-start cycle refuses requests so the commit
    // always uses the value held before that cycle.
    assign CFG_READY = ~VID_RST &
                       ((r_state == IDLE) | ((r_state == PENDING) & ~w_vs_rise));
    assign w_xfer    = CFG_VALID & CFG_READY;
    assign w_legal   = cfg_is_legal(CFG_TRANSFER_MODE, CFG_RAW_BIT_NUM);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_store     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            IDLE: begin
                // A frame start in IDLE is ignored; a request stored now
                // waits for the following frame start.
                if (w_xfer && w_legal) begin
                    w_store     = 1'b1;
                    w_state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (w_vs_rise) begin
                    w_commit    = 1'b1;
                    w_state_nxt = SETTLE;
                end else if (w_xfer && w_legal) begin
                    w_store     = 1'b1;
                end
            end
            SETTLE: begin
                if (r_settle_cnt == 8'd0) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge VID_CLK) begin
        if (VID_RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Pending / committed configuration and status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge VID_CLK) begin
        if (VID_RST) begin
            r_pend_mode   <= C_INIT_MODE_V;
            r_pend_bits   <= C_INIT_BITS_V;
            r_mode        <= C_INIT_MODE_V;
            r_bits        <= C_INIT_BITS_V;
            r_mode_update <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_settle_cnt  <= 8'd0;
        end else begin
            r_cfg_err     <= w_xfer & ~w_legal;
            r_mode_update <= w_commit;
            if (w_store) begin
                r_pend_mode <= CFG_TRANSFER_MODE;
                r_pend_bits <= CFG_RAW_BIT_NUM;
            end
            if (w_commit) begin
                r_mode       <= r_pend_mode;
                r_bits       <= r_pend_bits;
                r_settle_cnt <= C_SETTLE_LOAD;
            end else if (r_state == SETTLE && r_settle_cnt != 8'd0) begin
                r_settle_cnt <= r_settle_cnt - 8'd1;
            end
        end
    end

    assign TRANSFER_MODE = r_mode;
    assign RAW_BIT_NUM   = r_bits;
    assign MODE_UPDATE   = r_mode_update;
    assign CFG_ERR       = r_cfg_err;
    assign BUSY          = (r_state != IDLE);

endmodule : rgb_to_raw_mode_ctrl
`default_nettype wire

// File: tb/tb_rgb_to_raw_mode_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_to_raw_mode_ctrl
//  Description : Self-checking bench for rgb_to_raw_mode_ctrl. A table of
//                directed vectors, hand-written corner sequences and a
//                randomized run are all compared against a cycle-level
//                reference model of the mode sequencer and timing counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_to_raw_mode_ctrl;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_vs = 1'b0, s_hs = 1'b0, s_de = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_mode = 2'd0, cfg_bits = 2'd0;
    logic        cfg_ready, cfg_err, mode_update, busy;
    logic [1:0]  transfer_mode, raw_bit_num;
    logic [15:0] frame_cnt;
    logic [11:0] line_cnt;

    always #5 clk = ~clk;

    rgb_to_raw_mode_ctrl dut (
        .VID_CLK           (clk),
        .VID_RST           (rst),
        .S_VS              (s_vs),
        .S_HS              (s_hs),
        .S_DE              (s_de),
        .CFG_VALID         (cfg_valid),
        .CFG_READY         (cfg_ready),
        .CFG_TRANSFER_MODE (cfg_mode),
        .CFG_RAW_BIT_NUM   (cfg_bits),
        .CFG_ERR           (cfg_err),
        .TRANSFER_MODE     (transfer_mode),
        .RAW_BIT_NUM       (raw_bit_num),
        .MODE_UPDATE       (mode_update),
        .BUSY              (busy),
        .FRAME_CNT         (frame_cnt),
        .LINE_CNT          (line_cnt)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: committed settings, optional pending request, and
    // the edge index until which the converter is still settling.
    // ------------------------------------------------------------------
    int m_mode = 0, m_bits = 2;
    bit m_pend = 0;
    int m_pmode = 0, m_pbits = 0;
    int m_edges = 0, m_settle_end = 0;
    bit m_err = 0, m_upd = 0;
    int m_frame = 0, m_line = 0;
    bit m_vs_prev = 0, m_de_prev = 0;

    function automatic bit m_ready();
        bit settling, vs_rise;
        if (rst) return 1'b0;
        settling = (m_edges < m_settle_end);
        vs_rise  = s_vs && !m_vs_prev;
        return !settling && (!m_pend || !vs_rise);
    endfunction

    task automatic model_edge();
        bit vs_rise, de_fall, xfer, legal;
        if (rst) begin
            m_mode = 0; m_bits = 2; m_pend = 0; m_settle_end = 0;
            m_err = 0; m_upd = 0; m_frame = 0; m_line = 0;
            m_vs_prev = 0; m_de_prev = 0;
            m_edges++;
            return;
        end
        vs_rise = s_vs && !m_vs_prev;
        de_fall = !s_de && m_de_prev;
        xfer    = cfg_valid && m_ready();
        legal   = (cfg_mode != 2'd3) && (cfg_bits != 2'd3);
        m_err   = xfer && !legal;
        m_upd   = 0;
        m_edges++;
        if (m_pend && vs_rise) begin
            m_mode = m_pmode; m_bits = m_pbits; m_pend = 0; m_upd = 1;
            m_settle_end = m_edges + SETTLE;
        end else if (xfer && legal) begin
            m_pend = 1; m_pmode = cfg_mode; m_pbits = cfg_bits;
        end
        if (vs_rise) begin
            m_frame = (m_frame + 1) % 65536;
            m_line  = 0;
        end else if (de_fall && m_line < 4095) begin
            m_line = m_line + 1;
        end
        m_vs_prev = s_vs;
        m_de_prev = s_de;
    endtask

    // One clock: drive inputs, check READY before the edge, check the
    // registered outputs after it.
    task automatic step(input bit r, input bit vs, input bit hs, input bit de,
                        input bit v, input logic [1:0] tm, input logic [1:0] rb,
                        output logic rdy_seen);
        @(negedge clk);
        rst = r; s_vs = vs; s_hs = hs; s_de = de;
        cfg_valid = v; cfg_mode = tm; cfg_bits = rb;
        #1;
        rdy_seen = cfg_ready;
        chk("ready", 32'(cfg_ready), 32'(m_ready()));
        @(posedge clk);
        model_edge();
        #1;
        chk("mode",   32'(transfer_mode), 32'(m_mode));
        chk("bits",   32'(raw_bit_num),   32'(m_bits));
        chk("update", 32'(mode_update),   32'(m_upd));
        chk("busy",   32'(busy),          32'(m_pend || (m_edges < m_settle_end)));
        chk("err",    32'(cfg_err),       32'(m_err));
        chk("frame",  32'(frame_cnt),     32'(m_frame));
        chk("line",   32'(line_cnt),      32'(m_line));
    endtask

    task automatic idle(input int n, input bit vs, input bit de);
        logic rd;
        for (int i = 0; i < n; i++) step(0, vs, 0, de, 0, 2'd0, 2'd0, rd);
    endtask

    typedef struct {
        bit vs; bit de; bit v; logic [1:0] tm; logic [1:0] rb;
        bit e_rdy; logic [1:0] e_tm; logic [1:0] e_rb; bit e_upd; bit e_busy; bit e_err;
    } tv_t;

    tv_t tbl[14];

    function automatic tv_t mk(bit vs, bit de, bit v, logic [1:0] tm, logic [1:0] rb,
                               bit e_rdy, logic [1:0] e_tm, logic [1:0] e_rb,
                               bit e_upd, bit e_busy, bit e_err);
        tv_t t;
        t.vs = vs; t.de = de; t.v = v; t.tm = tm; t.rb = rb;
        t.e_rdy = e_rdy; t.e_tm = e_tm; t.e_rb = e_rb;
        t.e_upd = e_upd; t.e_busy = e_busy; t.e_err = e_err;
        return t;
    endfunction

    initial begin
        logic rd;
        int   f0, vs_timer, de_timer;
        bit   vs_r, de_r, v_r;

        //            vs de v  tm    rb     rdy tm    rb    upd busy err
        tbl[0]  = mk(0, 0, 0, 2'd0, 2'd0,  1, 2'd0, 2'd2, 0, 0, 0); // reset state
        tbl[1]  = mk(0, 0, 1, 2'd1, 2'd1,  1, 2'd0, 2'd2, 0, 1, 0); // request (1,1)
        tbl[2]  = mk(0, 0, 0, 2'd0, 2'd0,  1, 2'd0, 2'd2, 0, 1, 0); // held mid-frame
        tbl[3]  = mk(1, 0, 0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 1, 1, 0); // frame start commits
        tbl[4]  = mk(1, 0, 0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 0, 1, 0);
        tbl[5]  = mk(0, 0, 0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 0, 1, 0);
        tbl[6]  = mk(0, 0, 0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 2'd0, 2'd0,  0, 2'd1, 2'd1, 0, 0, 0); // settle over
        tbl[8]  = mk(0, 0, 1, 2'd3, 2'd0,  1, 2'd1, 2'd1, 0, 0, 1); // illegal accepted
        tbl[9]  = mk(0, 0, 0, 2'd0, 2'd0,  1, 2'd1, 2'd1, 0, 0, 0); // err is one pulse
        tbl[10] = mk(0, 0, 1, 2'd1, 2'd0,  1, 2'd1, 2'd1, 0, 1, 0);
        tbl[11] = mk(0, 0, 1, 2'd2, 2'd2,  1, 2'd1, 2'd1, 0, 1, 0); // latest wins
        tbl[12] = mk(1, 0, 1, 2'd0, 2'd0,  0, 2'd2, 2'd2, 1, 1, 0); // refused on rise
        tbl[13] = mk(0, 0, 0, 2'd0, 2'd0,  0, 2'd2, 2'd2, 0, 1, 0);

        // Reset
        step(1, 0, 0, 0, 0, 2'd0, 2'd0, rd);
        step(1, 0, 0, 0, 0, 2'd0, 2'd0, rd);

        foreach (tbl[i]) begin
            step(0, tbl[i].vs, 0, tbl[i].de, tbl[i].v, tbl[i].tm, tbl[i].rb, rd);
            chk($sformatf("tbl%0d_ready", i), 32'(rd),            32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_mode",  i), 32'(transfer_mode), 32'(tbl[i].e_tm));
            chk($sformatf("tbl%0d_bits",  i), 32'(raw_bit_num),   32'(tbl[i].e_rb));
            chk($sformatf("tbl%0d_upd",   i), 32'(mode_update),   32'(tbl[i].e_upd));
            chk($sformatf("tbl%0d_busy",  i), 32'(busy),          32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_err",   i), 32'(cfg_err),       32'(tbl[i].e_err));
        end
        idle(6, 0, 0);

        // Frame with sync pulses and two 100-cycle DE bursts
        f0 = m_frame;
        step(0, 1, 0, 0, 0, 2'd0, 2'd0, rd);
        idle(3, 0, 0);
        for (int b = 0; b < 2; b++) begin
            step(0, 0, 1, 0, 0, 2'd0, 2'd0, rd);
            step(0, 0, 0, 0, 0, 2'd0, 2'd0, rd);
            for (int c = 0; c < 100; c++) step(0, 0, 0, 1, 0, 2'd0, 2'd0, rd);
            step(0, 0, 1, 0, 0, 2'd0, 2'd0, rd);
            idle(4, 0, 0);
        end
        chk("frame_plus1", 32'(frame_cnt), 32'((f0 + 1) % 65536));
        chk("lines_2",     32'(line_cnt),  32'd2);
        step(0, 1, 0, 0, 0, 2'd0, 2'd0, rd);
        chk("lines_clr",   32'(line_cnt),  32'd0);
        idle(2, 0, 0);

        // Coincident frame start and line end: clear wins
        step(0, 0, 0, 1, 0, 2'd0, 2'd0, rd);
        step(0, 1, 0, 0, 0, 2'd0, 2'd0, rd);
        chk("clr_wins", 32'(line_cnt), 32'd0);
        idle(2, 0, 0);

        // Reset while pending discards the request
        step(0, 0, 0, 0, 1, 2'd2, 2'd0, rd);
        chk("pend_busy", 32'(busy), 32'd1);
        step(1, 0, 0, 0, 0, 2'd0, 2'd0, rd);
        chk("rst_mode", 32'(transfer_mode), 32'd0);
        chk("rst_bits", 32'(raw_bit_num),   32'd2);
        chk("rst_busy", 32'(busy),          32'd0);
        step(0, 1, 0, 0, 0, 2'd0, 2'd0, rd);
        chk("no_commit_upd",  32'(mode_update),   32'd0);
        chk("no_commit_mode", 32'(transfer_mode), 32'd0);
        idle(3, 0, 0);
        chk("no_commit_upd2", 32'(mode_update), 32'd0);

        // Line counter saturation
        for (int i = 0; i < 4100; i++) begin
            step(0, 0, 0, 1, 0, 2'd0, 2'd0, rd);
            step(0, 0, 0, 0, 0, 2'd0, 2'd0, rd);
        end
        chk("line_sat", 32'(line_cnt), 32'd4095);

        // Randomized traffic against the model
        vs_timer = 20; de_timer = 0; de_r = 0;
        for (int i = 0; i < 3000; i++) begin
            vs_timer--;
            vs_r = (vs_timer <= 1);
            if (vs_timer <= 0) vs_timer = $urandom_range(80, 15);
            if (de_timer == 0) begin
                de_r = ~de_r;
                de_timer = $urandom_range(12, 1);
            end
            de_timer--;
            v_r = ($urandom_range(3, 0) == 0);
            step(($urandom_range(299, 0) == 0), vs_r, 1'($urandom), de_r, v_r,
                 2'($urandom), 2'($urandom), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_rgb_to_raw_mode_ctrl
`default_nettype wire
